// File: rtl/i2cs_reg_access_arb_if.sv
// Requester and register-port bundle for the I2C-slave register access arbiter.
// slave = arbiter view, master = requesters plus register model view.
`timescale 1ns/1ps
interface i2cs_reg_access_arb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  r0_req_i;
  logic                  r0_we_i;
  logic [ADDR_WIDTH-1:0] r0_addr_i;
  logic [DATA_WIDTH-1:0] r0_wdata_i;
  logic                  r0_ack_o;
  logic [DATA_WIDTH-1:0] r0_rdata_o;
  logic                  r1_req_i;
  logic                  r1_we_i;
  logic [ADDR_WIDTH-1:0] r1_addr_i;
  logic [DATA_WIDTH-1:0] r1_wdata_i;
  logic                  r1_ack_o;
  logic [DATA_WIDTH-1:0] r1_rdata_o;
  logic [ADDR_WIDTH-1:0] reg_waddr_o;
  logic [DATA_WIDTH-1:0] reg_wdata_o;
  logic                  reg_wrenable_o;
  logic [ADDR_WIDTH-1:0] reg_raddr_o;
  logic [DATA_WIDTH-1:0] reg_rdata_i;
  logic                  reg_rd_byte_complete_o;
  logic                  busy_o;
  logic                  grant_o;

  modport slave (
    input  r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
    input  r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
    input  reg_rdata_i,
    output r0_ack_o, r0_rdata_o, r1_ack_o, r1_rdata_o,
    output reg_waddr_o, reg_wdata_o, reg_wrenable_o, reg_raddr_o,
    output reg_rd_byte_complete_o, busy_o, grant_o
  );

  modport master (
    output r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
    output r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
    output reg_rdata_i,
    input  r0_ack_o, r0_rdata_o, r1_ack_o, r1_rdata_o,
    input  reg_waddr_o, reg_wdata_o, reg_wrenable_o, reg_raddr_o,
    input  reg_rd_byte_complete_o, busy_o, grant_o
  );
endinterface

// File: rtl/i2cs_reg_access_arb.sv
// Two-requester (APB=r0, I2C engine=r1) arbiter sequencing accesses onto one register port.
// Define I2CS_REG_ARB_FIXED_PRIO_EN for fixed r0 priority; default is round-robin.
//
//   state  | meaning
//   IDLE   | no owner; arbitrate and latch winner's request fields
//   ACCESS | write strobe (one cycle) or read address held for RD_WAIT+1 cycles
//   DONE   | one-cycle ack to the owner
`timescale 1ns/1ps
module i2cs_reg_access_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WAIT    = 1
) (
  input logic                  apb_pclk_i,
  input logic                  apb_presetn_i,
  i2cs_reg_access_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  win;

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Winner is only meaningful when at least one request is high.
`ifdef I2CS_REG_ARB_FIXED_PRIO_EN
  assign win = ~bus.r0_req_i;
`else
  assign win = (bus.r0_req_i && bus.r1_req_i) ? ~last_q : bus.r1_req_i;
`endif

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (bus.r0_req_i || bus.r1_req_i) begin
          id_d    = win;
          we_d    = win ? bus.r1_we_i    : bus.r0_we_i;
          addr_d  = win ? bus.r1_addr_i  : bus.r0_addr_i;
          wdata_d = win ? bus.r1_wdata_i : bus.r0_wdata_i;
          cnt_d   = 3'(RD_WAIT);
          last_d  = win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (id_q) rdata1_d = bus.reg_rdata_i;
          else      rdata0_d = bus.reg_rdata_i;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  assign bus.busy_o                 = (state_q != IDLE);
  assign bus.grant_o                = id_q;
  assign bus.reg_waddr_o            = addr_q;
  assign bus.reg_wdata_o            = wdata_q;
  assign bus.reg_raddr_o            = addr_q;
  assign bus.reg_wrenable_o         = (state_q == ACCESS) && we_q;
  assign bus.reg_rd_byte_complete_o = (state_q == ACCESS) && !we_q && (cnt_q == 3'd0);
  assign bus.r0_ack_o               = (state_q == DONE) && !id_q;
  assign bus.r1_ack_o               = (state_q == DONE) && id_q;
  assign bus.r0_rdata_o             = rdata0_q;
  assign bus.r1_rdata_o             = rdata1_q;

endmodule

// File: tb/tb_i2cs_reg_access_arb.sv
// Scoreboard bench for i2cs_reg_access_arb: main instance RD_WAIT=1, plus RD_WAIT=0 and RD_WAIT=7 instances.
`timescale 1ns/1ps
module tb_i2cs_reg_access_arb;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RDW [3] = '{1, 0, 7};

  typedef struct {
    bit           id;
    bit           we;
    logic [11:0]  addr;
    logic [31:0]  data;
    int unsigned  t_evt;
    int unsigned  t_ack;
    bit           seen;
  } exp_t;

  typedef struct {
    string        nm;
    logic [63:0]  act;
    logic [63:0]  exp;
  } dchk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q [3][$];
  dchk_t       dq [$];

  logic        req [3][2];
  logic        we  [3][2];
  logic [11:0] adr [3][2];
  logic [31:0] wd  [3][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2cs_reg_access_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  i2cs_reg_access_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
  i2cs_reg_access_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_c ();

  i2cs_reg_access_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(1)) dut_a (
    .apb_pclk_i(clk), .apb_presetn_i(rst_n), .bus(bus_a.slave));
  i2cs_reg_access_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(0)) dut_b (
    .apb_pclk_i(clk), .apb_presetn_i(rst_n), .bus(bus_b.slave));
  i2cs_reg_access_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(7)) dut_c (
    .apb_pclk_i(clk), .apb_presetn_i(rst_n), .bus(bus_c.slave));

  function automatic logic [31:0] reg_model(input logic [11:0] a);
    case (a)
      12'h010: return 32'h1234_5678;
      12'h014: return 32'hCAFE_0014;
      default: return 32'h5A00_0000 | {20'h0, a};
    endcase
  endfunction

  assign bus_a.reg_rdata_i = reg_model(bus_a.reg_raddr_o);
  assign bus_b.reg_rdata_i = reg_model(bus_b.reg_raddr_o);
  assign bus_c.reg_rdata_i = reg_model(bus_c.reg_raddr_o);

  assign bus_a.r0_req_i = req[0][0]; assign bus_a.r0_we_i = we[0][0];
  assign bus_a.r0_addr_i = adr[0][0]; assign bus_a.r0_wdata_i = wd[0][0];
  assign bus_a.r1_req_i = req[0][1]; assign bus_a.r1_we_i = we[0][1];
  assign bus_a.r1_addr_i = adr[0][1]; assign bus_a.r1_wdata_i = wd[0][1];
  assign bus_b.r0_req_i = req[1][0]; assign bus_b.r0_we_i = we[1][0];
  assign bus_b.r0_addr_i = adr[1][0]; assign bus_b.r0_wdata_i = wd[1][0];
  assign bus_b.r1_req_i = req[1][1]; assign bus_b.r1_we_i = we[1][1];
  assign bus_b.r1_addr_i = adr[1][1]; assign bus_b.r1_wdata_i = wd[1][1];
  assign bus_c.r0_req_i = req[2][0]; assign bus_c.r0_we_i = we[2][0];
  assign bus_c.r0_addr_i = adr[2][0]; assign bus_c.r0_wdata_i = wd[2][0];
  assign bus_c.r1_req_i = req[2][1]; assign bus_c.r1_we_i = we[2][1];
  assign bus_c.r1_addr_i = adr[2][1]; assign bus_c.r1_wdata_i = wd[2][1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Direct checks from the stimulus side are queued and evaluated by the monitor.
  task automatic post(input string nm, input logic [63:0] act, input logic [63:0] exp);
    dchk_t d;
    d.nm = nm; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic mon(input int k, input logic ack0, input logic ack1, input logic cpl,
                     input logic wren, input logic busy, input logic grant,
                     input logic [11:0] waddr, input logic [11:0] raddr,
                     input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1);
    exp_t e;
    if (wren) begin
      if (exp_q[k].size() == 0) chk($sformatf("u%0d_unexpected_wren", k), 1, 0);
      else begin
        e = exp_q[k].pop_front();
        chk($sformatf("u%0d_wren_on_write", k), e.we, 1);
        chk($sformatf("u%0d_wren_cycle", k), cyc, e.t_evt);
        chk($sformatf("u%0d_waddr", k), waddr, e.addr);
        chk($sformatf("u%0d_wdata", k), wdata, e.data);
        chk($sformatf("u%0d_wren_grant", k), grant, e.id);
        e.seen = 1'b1;
        exp_q[k].push_front(e);
      end
    end
    if (cpl) begin
      if (exp_q[k].size() == 0) chk($sformatf("u%0d_unexpected_rd_complete", k), 1, 0);
      else begin
        e = exp_q[k].pop_front();
        chk($sformatf("u%0d_cpl_on_read", k), e.we, 0);
        chk($sformatf("u%0d_cpl_cycle", k), cyc, e.t_evt);
        chk($sformatf("u%0d_raddr", k), raddr, e.addr);
        e.seen = 1'b1;
        exp_q[k].push_front(e);
      end
    end
    if (ack0 || ack1) begin
      if (exp_q[k].size() == 0) chk($sformatf("u%0d_unexpected_ack", k), 1, 0);
      else begin
        e = exp_q[k].pop_front();
        chk($sformatf("u%0d_ack_id", k), {ack1, ack0}, e.id ? 2'b10 : 2'b01);
        chk($sformatf("u%0d_ack_cycle", k), cyc, e.t_ack);
        chk($sformatf("u%0d_access_seen", k), e.seen, 1);
        chk($sformatf("u%0d_busy_grant_at_ack", k), {busy, grant}, {1'b1, e.id});
        if (!e.we) chk($sformatf("u%0d_rdata", k), e.id ? rd1 : rd0, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.r0_ack_o, bus_a.r1_ack_o, bus_a.reg_rd_byte_complete_o, bus_a.reg_wrenable_o,
        bus_a.busy_o, bus_a.grant_o, bus_a.reg_waddr_o, bus_a.reg_raddr_o, bus_a.reg_wdata_o,
        bus_a.r0_rdata_o, bus_a.r1_rdata_o);
    mon(1, bus_b.r0_ack_o, bus_b.r1_ack_o, bus_b.reg_rd_byte_complete_o, bus_b.reg_wrenable_o,
        bus_b.busy_o, bus_b.grant_o, bus_b.reg_waddr_o, bus_b.reg_raddr_o, bus_b.reg_wdata_o,
        bus_b.r0_rdata_o, bus_b.r1_rdata_o);
    mon(2, bus_c.r0_ack_o, bus_c.r1_ack_o, bus_c.reg_rd_byte_complete_o, bus_c.reg_wrenable_o,
        bus_c.busy_o, bus_c.grant_o, bus_c.reg_waddr_o, bus_c.reg_raddr_o, bus_c.reg_wdata_o,
        bus_c.r0_rdata_o, bus_c.r1_rdata_o);
    while (dq.size() > 0) begin
      dchk_t d;
      d = dq.pop_front();
      chk(d.nm, d.act, d.exp);
    end
  end

  function automatic logic get_ack(input int k, input bit id);
    case (k)
      0:       return id ? bus_a.r1_ack_o : bus_a.r0_ack_o;
      1:       return id ? bus_b.r1_ack_o : bus_b.r0_ack_o;
      default: return id ? bus_c.r1_ack_o : bus_c.r0_ack_o;
    endcase
  endfunction

  task automatic check_main_zero(input string tag);
    post({tag, "_ctl_outputs"}, {bus_a.r0_ack_o, bus_a.r1_ack_o, bus_a.reg_rd_byte_complete_o,
         bus_a.reg_wrenable_o, bus_a.busy_o, bus_a.grant_o, bus_a.reg_waddr_o, bus_a.reg_raddr_o}, 0);
    post({tag, "_rdata_outputs"}, {bus_a.r1_rdata_o, bus_a.r0_rdata_o}, 0);
    post({tag, "_wdata_output"}, bus_a.reg_wdata_o, 0);
  endtask

  // One transaction from requester id of instance k; returns at the negedge where ack is seen.
  task automatic do_req(input int k, input bit id, input bit w, input logic [11:0] a,
                        input logic [31:0] d, input logic [31:0] rexp, input bit withdraw);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.id = id; e.we = w; e.addr = a; e.data = w ? d : rexp; e.seen = 1'b0;
    e.t_evt = cyc + 1 + (w ? 0 : RDW[k]);
    e.t_ack = e.t_evt + 1;
    exp_q[k].push_back(e);
    req[k][id] = 1'b1; we[k][id] = w; adr[k][id] = a; wd[k][id] = d;
    if (withdraw) begin
      @(negedge clk);
      req[k][id] = 1'b0; we[k][id] = ~w; adr[k][id] = 12'h3FC; wd[k][id] = 32'hFFFF_FFFF;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_ack(k, id)) begin
        got = 1'b1;
        break;
      end
    end
    req[k][id] = 1'b0;
    if (!got) post($sformatf("u%0d_r%0d_ack_timeout", k, id), 1, 0);
  endtask

  initial begin
    exp_t e;
    int   n_ack;
    int unsigned c;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 2; j++) begin
        req[k][j] = 1'b0; we[k][j] = 1'b0; adr[k][j] = '0; wd[k][j] = '0;
      end
    repeat (3) @(negedge clk);
    check_main_zero("reset");
    rst_n = 1'b1;

    // Write latency and idle after ack.
    do_req(0, 0, 1, 12'h004, 32'hA5A5_0001, 0, 0);
    @(negedge clk);
    post("t1_busy_low_T3", bus_a.busy_o, 0);

    // r1 read, then r0 read must not disturb r1's captured data.
    do_req(0, 1, 0, 12'h010, 0, 32'h1234_5678, 0);
    do_req(0, 0, 0, 12'h014, 0, 32'hCAFE_0014, 0);
    @(negedge clk);
    post("t2_r1_rdata_held", bus_a.r1_rdata_o, 32'h1234_5678);

    // r1 withdraws and changes fields during ACCESS of its write.
    do_req(0, 1, 1, 12'h020, 32'h2020_2020, 0, 1);
    @(negedge clk);
    post("t4_r1_rdata_after_write", bus_a.r1_rdata_o, 32'h1234_5678);
    post("t4_r0_rdata_untouched", bus_a.r0_rdata_o, 32'hCAFE_0014);

    // Reset in the middle of a read: no ack, no completion, everything cleared.
    @(negedge clk);
    req[0][0] = 1'b1; we[0][0] = 1'b0; adr[0][0] = 12'h030;
    @(negedge clk);
    post("t5_in_access", bus_a.busy_o, 1);
    #2 rst_n = 1'b0;
    req[0][0] = 1'b0;
    #1 check_main_zero("t5_async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 0, 1, 12'h008, 32'h0000_0808, 0, 0);

    // Fresh reset so arbitration starts from the reset pointer.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous contention for six transactions.
    @(negedge clk);
    c = cyc;
    for (int j = 0; j < 6; j++) begin
`ifdef I2CS_REG_ARB_FIXED_PRIO_EN
      e.id = 1'b0;
`else
      e.id = (j % 2 == 1);
`endif
      e.we = 1'b1; e.seen = 1'b0;
      e.addr = e.id ? 12'h104 : 12'h100;
      e.data = e.id ? 32'h0000_0104 : 32'h0000_0100;
      e.t_evt = c + 1 + 3 * j;
      e.t_ack = c + 2 + 3 * j;
      exp_q[0].push_back(e);
    end
    req[0][0] = 1'b1; we[0][0] = 1'b1; adr[0][0] = 12'h100; wd[0][0] = 32'h0000_0100;
    req[0][1] = 1'b1; we[0][1] = 1'b1; adr[0][1] = 12'h104; wd[0][1] = 32'h0000_0104;
    n_ack = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_a.r0_ack_o || bus_a.r1_ack_o) n_ack++;
      if (n_ack == 6) break;
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    if (n_ack != 6) post("t3_ack_count_timeout", n_ack, 6);

    // Read wait extremes.
    do_req(1, 0, 0, 12'h010, 0, 32'h1234_5678, 0);
    do_req(2, 0, 0, 12'h014, 0, 32'hCAFE_0014, 0);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) post($sformatf("u%0d_drain", k), exp_q[k].size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
